fe_fetch_queue: RTL and testbench



---
 rtl/fe_fetch_queue_pkg.sv | 22 ++
 rtl/fe_inst_fifo.sv | 59 +++++
 rtl/fe_fetch_queue.sv | 131 +++++++++++++
 tb/tb_fe_fetch_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_fetch_queue_pkg.sv
// Shared FE latch layout for fe_fetch_queue and the decode stage that unpacks it.
// Latch packing, MSB first: {inst, pc, pcplus, inst_count, bus_canary}.
package fe_fetch_queue_pkg;

    localparam int unsigned FE_DBITS        = 32;
    localparam int unsigned FE_INSTBITS     = 32;
    localparam int unsigned FE_CANARY_WIDTH = 4;
    localparam logic [FE_CANARY_WIDTH-1:0] FE_CANARY_VAL = 4'hF;

    // {br_redirect, br_target}
    localparam int unsigned FE_AGEX_WIDTH  = 1 + FE_DBITS;
    localparam int unsigned FE_LATCH_WIDTH = FE_INSTBITS + 3*FE_DBITS + FE_CANARY_WIDTH;

    localparam int unsigned FE_CANARY_LSB = 0;
    localparam int unsigned FE_COUNT_LSB  = FE_CANARY_LSB + FE_CANARY_WIDTH;
    localparam int unsigned FE_PCPLUS_LSB = FE_COUNT_LSB + FE_DBITS;
    localparam int unsigned FE_PC_LSB     = FE_PCPLUS_LSB + FE_DBITS;
    localparam int unsigned FE_INST_LSB   = FE_PC_LSB + FE_DBITS;

    localparam logic [FE_LATCH_WIDTH-1:0] FE_BUBBLE = '0;

endpackage

// File: rtl/fe_inst_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched {inst, pc, pcplus} entries.
// Flush has priority over push; overflow/underflow are assertion failures.
module fe_inst_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign head  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    ovf_a: assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop && !flush));
    udf_a: assert property (@(posedge clk) disable iff (!reset) !(pop && empty && !flush));

endmodule

// File: rtl/fe_fetch_queue.sv
// Fetch stage: credit-based requests to a 1-cycle imem, response queue, FE latch.
// Define FE_PERF_CNT_EN to add perf_stall_cycles / perf_flushes counters.
module fe_fetch_queue
    import fe_fetch_queue_pkg::*;
#(
    parameter int unsigned DBITS        = FE_DBITS,
    parameter int unsigned INSTBITS     = FE_INSTBITS,
    parameter int unsigned QDEPTH       = 2,
    parameter logic [DBITS-1:0] START_PC = '0,
    parameter int unsigned CANARY_WIDTH = FE_CANARY_WIDTH,
    parameter logic [CANARY_WIDTH-1:0] CANARY_VAL = FE_CANARY_VAL
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     from_DE_to_FE,
    input  logic [DBITS:0]                           from_AGEX_to_FE,
    output logic                                     imem_req_valid,
    output logic [DBITS-1:0]                         imem_req_addr,
    input  logic                                     imem_rsp_valid,
    input  logic [INSTBITS-1:0]                      imem_rsp_data,
    output logic [INSTBITS+3*DBITS+CANARY_WIDTH-1:0] FE_latch_out
`ifdef FE_PERF_CNT_EN
    ,
    output logic [31:0]                              perf_stall_cycles,
    output logic [31:0]                              perf_flushes
`endif
);

    localparam int unsigned ENTRY_W = INSTBITS + 2*DBITS;
    localparam int unsigned LATCH_W = INSTBITS + 3*DBITS + CANARY_WIDTH;
    localparam int unsigned CW      = $clog2(QDEPTH) + 1;

    logic               br_redirect;
    logic [DBITS-1:0]   br_target;
    logic               stall;

    logic [DBITS-1:0]   pc_q;
    logic [DBITS-1:0]   req_pc_q;
    logic [DBITS-1:0]   inst_count_q;
    logic               inflight_q;
    logic               kill_q;
    logic [LATCH_W-1:0] latch_q;

    logic [CW-1:0]      q_count;
    logic               q_full;
    logic               q_empty;
    logic [ENTRY_W-1:0] q_head;
    logic [ENTRY_W-1:0] rsp_entry;
    logic [ENTRY_W-1:0] load_entry;

    logic issue, rsp_ok, bypass, q_push, q_pop;

    assign {br_redirect, br_target} = from_AGEX_to_FE;
    assign stall = from_DE_to_FE;

    // Credit counts queued entries plus the request in flight, so every response has a slot.
    assign issue  = reset && !br_redirect && ((32'(q_count) + 32'(inflight_q)) < QDEPTH);
    assign rsp_ok = imem_rsp_valid && inflight_q && !kill_q;

    assign rsp_entry  = {imem_rsp_data, req_pc_q, req_pc_q + DBITS'(4)};
    assign bypass     = rsp_ok && q_empty && !br_redirect && !stall;
    assign q_pop      = !q_empty && !br_redirect && !stall;
    assign q_push     = rsp_ok && !br_redirect && !bypass;
    assign load_entry = q_pop ? q_head : rsp_entry;

    assign imem_req_valid = issue;
    assign imem_req_addr  = pc_q;
    assign FE_latch_out   = latch_q;

    fe_inst_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (br_redirect),
        .push_data (rsp_entry),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= START_PC;
            req_pc_q     <= '0;
            inst_count_q <= '0;
            inflight_q   <= 1'b0;
            kill_q       <= 1'b0;
            latch_q      <= '0;
        end else begin
            inflight_q <= issue;
            kill_q     <= br_redirect && issue;
            if (issue) req_pc_q <= pc_q;

            if (br_redirect)  pc_q <= {br_target[DBITS-1:2], 2'b00};
            else if (issue)   pc_q <= pc_q + DBITS'(4);

            if (br_redirect) begin
                latch_q <= '0;
            end else if (!stall) begin
                if (q_pop || bypass) begin
                    latch_q      <= {load_entry, inst_count_q, CANARY_VAL};
                    inst_count_q <= inst_count_q + DBITS'(1);
                end else begin
                    latch_q <= '0;
                end
            end
        end
    end

    full_credit_a: assert property (@(posedge clk) disable iff (!reset) !(q_full && issue));

`ifdef FE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
        end else begin
            if (stall && (latch_q != '0) && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (br_redirect && (!q_empty || inflight_q) && (perf_flushes != '1))
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fe_fetch_queue.sv
// Self-checking bench for fe_fetch_queue: directed vector table, reset corner, random vs queue model.
module tb_fe_fetch_queue;
    import fe_fetch_queue_pkg::*;

    localparam int unsigned QDEPTH = 2;
    localparam int unsigned LW     = FE_LATCH_WIDTH;

    logic                     clk;
    logic                     reset;
    logic                     from_DE_to_FE;
    logic [FE_AGEX_WIDTH-1:0] from_AGEX_to_FE;
    logic                     imem_req_valid;
    logic [31:0]              imem_req_addr;
    logic                     imem_rsp_valid;
    logic [31:0]              imem_rsp_data;
    logic [LW-1:0]            FE_latch_out;
`ifdef FE_PERF_CNT_EN
    logic [31:0]              perf_stall_cycles;
    logic [31:0]              perf_flushes;
`endif

    fe_fetch_queue #(
        .DBITS        (32),
        .INSTBITS     (32),
        .QDEPTH       (QDEPTH),
        .START_PC     (32'h0),
        .CANARY_WIDTH (4),
        .CANARY_VAL   (4'hF)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .from_DE_to_FE   (from_DE_to_FE),
        .from_AGEX_to_FE (from_AGEX_to_FE),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .FE_latch_out    (FE_latch_out)
`ifdef FE_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic rand_data = 1'b0;

    // imem: behaves as a pure function of the word address
    logic        pend_v = 1'b0;
    logic [31:0] pend_a = '0;

    // reference model: instruction queue + in-flight list
    typedef struct packed { logic [31:0] inst; logic [31:0] pc; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_infl[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [LW-1:0] m_latch;

    typedef struct {
        logic st; logic rd; logic [31:0] tg;
        logic ev; logic [31:0] ea;
        logic lv; logic [31:0] lpc; logic [31:0] lcnt;
    } vec_t;
    vec_t vq[$];

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        if (!rand_data) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [LW-1:0] mk_latch(input logic [31:0] inst, input logic [31:0] pc,
                                               input logic [31:0] cnt);
        logic [LW-1:0] v;
        v = FE_BUBBLE;
        v[FE_INST_LSB +: 32]   = inst;
        v[FE_PC_LSB +: 32]     = pc;
        v[FE_PCPLUS_LSB +: 32] = pc + 32'd4;
        v[FE_COUNT_LSB +: 32]  = cnt;
        v[FE_CANARY_LSB +: 4]  = FE_CANARY_VAL;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl.delete();
        m_pc    = 32'h0;
        m_cnt   = 32'h0;
        m_latch = FE_BUBBLE;
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] tg,
                              output logic ev, output logic [31:0] ea);
        logic        have;
        logic [31:0] rpc;
        ent_t        e;
        ev   = !rd && ((mq.size() + m_infl.size()) < QDEPTH);
        ea   = m_pc;
        have = 1'b0;
        rpc  = '0;
        if (m_infl.size() > 0) begin
            rpc  = m_infl.pop_front();
            have = 1'b1;
        end
        if (rd) begin
            mq.delete();
            m_latch = FE_BUBBLE;
            m_pc    = {tg[31:2], 2'b00};
        end else begin
            if (have) mq.push_back('{imem_fn(rpc), rpc});
            if (!st) begin
                if (mq.size() > 0) begin
                    e       = mq.pop_front();
                    m_latch = mk_latch(e.inst, e.pc, m_cnt);
                    m_cnt   = m_cnt + 32'd1;
                end else begin
                    m_latch = FE_BUBBLE;
                end
            end
            if (ev) m_pc = m_pc + 32'd4;
        end
        if (ev) m_infl.push_back(ea);
    endtask

    // One cycle: drive inputs just after a posedge, check request, check latch after next posedge.
    task automatic tick(input logic st, input logic rd, input logic [31:0] tg,
                        output logic rv, output logic [31:0] ra);
        logic        ev;
        logic [31:0] ea;
        from_DE_to_FE   = st;
        from_AGEX_to_FE = {rd, tg};
        imem_rsp_valid  = pend_v;
        imem_rsp_data   = pend_v ? imem_fn(pend_a) : 32'h0;
        #1;
        rv = imem_req_valid;
        ra = imem_req_addr;
        model_step(st, rd, tg, ev, ea);
        chk("model_req_valid", LW'(rv), LW'(ev));
        if (ev) chk("model_req_addr", LW'(ra), LW'(ea));
        @(posedge clk);
        #1;
        pend_v = rv;
        pend_a = ra;
        chk("model_latch", FE_latch_out, m_latch);
    endtask

    task automatic add(input logic st, input logic rd, input logic [31:0] tg, input logic ev,
                       input logic [31:0] ea, input logic lv, input logic [31:0] lpc,
                       input logic [31:0] lcnt);
        vec_t v;
        v = '{st, rd, tg, ev, ea, lv, lpc, lcnt};
        vq.push_back(v);
    endtask

    initial begin
        logic        rv;
        logic [31:0] ra;
        logic        st, rd;
        logic [31:0] tg;
        string       nm;

        // stall, redir, target | exp req_valid, req_addr | exp latch valid, pc, count
        add(0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   0);
        add(0, 0, 32'h0,   1, 32'h4,   1, 32'h0,   0);
        add(0, 0, 32'h0,   1, 32'h8,   1, 32'h4,   1);
        add(0, 0, 32'h0,   1, 32'hC,   1, 32'h8,   2);
        add(1, 0, 32'h0,   1, 32'h10,  1, 32'h8,   2);
        add(1, 0, 32'h0,   0, 32'h0,   1, 32'h8,   2);
        add(1, 0, 32'h0,   0, 32'h0,   1, 32'h8,   2);
        add(1, 0, 32'h0,   0, 32'h0,   1, 32'h8,   2);
        add(1, 0, 32'h0,   0, 32'h0,   1, 32'h8,   2);
        add(0, 0, 32'h0,   0, 32'h0,   1, 32'hC,   3);
        add(0, 0, 32'h0,   1, 32'h14,  1, 32'h10,  4);
        add(0, 0, 32'h0,   1, 32'h18,  1, 32'h14,  5);
        add(1, 0, 32'h0,   1, 32'h1C,  1, 32'h14,  5);
        add(1, 0, 32'h0,   0, 32'h0,   1, 32'h14,  5);
        add(0, 1, 32'h100, 0, 32'h0,   0, 32'h0,   0);
        add(0, 0, 32'h0,   1, 32'h100, 0, 32'h0,   0);
        add(0, 0, 32'h0,   1, 32'h104, 1, 32'h100, 6);
        add(0, 1, 32'h202, 0, 32'h0,   0, 32'h0,   0);
        add(0, 0, 32'h0,   1, 32'h200, 0, 32'h0,   0);
        add(0, 0, 32'h0,   1, 32'h204, 1, 32'h200, 7);
        add(0, 0, 32'h0,   1, 32'h208, 1, 32'h204, 8);
        add(1, 1, 32'h300, 0, 32'h0,   0, 32'h0,   0);
        add(0, 0, 32'h0,   1, 32'h300, 0, 32'h0,   0);
        add(0, 0, 32'h0,   1, 32'h304, 1, 32'h300, 9);

        reset           = 1'b0;
        from_DE_to_FE   = 1'b0;
        from_AGEX_to_FE = '0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_latch", FE_latch_out, FE_BUBBLE);
        chk("reset_req_valid", LW'(imem_req_valid), LW'(1'b0));
        reset = 1'b1;

        foreach (vq[i]) begin
            tick(vq[i].st, vq[i].rd, vq[i].tg, rv, ra);
            nm = $sformatf("vec%0d", i);
            chk({nm, "_req_valid"}, LW'(rv), LW'(vq[i].ev));
            if (vq[i].ev) chk({nm, "_req_addr"}, LW'(ra), LW'(vq[i].ea));
            chk({nm, "_latch"}, FE_latch_out,
                vq[i].lv ? mk_latch(32'h13, vq[i].lpc, vq[i].lcnt) : FE_BUBBLE);
        end

        // reset mid-stream with the request for 32'h304 still in flight
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_latch", FE_latch_out, FE_BUBBLE);
        chk("midrst_req_valid", LW'(imem_req_valid), LW'(1'b0));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(0, 0, 32'h0, rv, ra);
        chk("postrst_req", LW'({rv, ra}), LW'({1'b1, 32'h0}));
        chk("postrst_stale_rsp", FE_latch_out, FE_BUBBLE);
        tick(0, 0, 32'h0, rv, ra);
        chk("postrst_first", FE_latch_out, mk_latch(32'h13, 32'h0, 32'h0));

        rand_data = 1'b1;
        for (int unsigned i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 19) == 0);
            tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom();
            tick(st, rd, tg, rv, ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
